// File: rtl/async_fifo.sv
// async_fifo: single-clock FIFO with registered read data.
// Despite the name, both sides run on one clock, clk.
// Depth is 2**ADDR_WIDTH entries. Each pointer carries one extra wrap bit,
// so a full FIFO and an empty FIFO can be told apart.
// Optional build macro FIFO_STATUS_EN adds three outputs:
//   - level: occupancy count
//   - overflow, underflow: sticky error flags, cleared only by reset_n
module async_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty
`ifdef FIFO_STATUS_EN
    ,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   wr_ptr_next;
    logic [ADDR_WIDTH:0]   rd_ptr_next;
    logic                  wr_accept;
    logic                  rd_accept;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Flags come straight from the registered pointers.
    // Each side is qualified against the flags as they stood before the edge.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        empty       = 1'b0;
        full        = 1'b0;
        wr_accept   = 1'b0;
        rd_accept   = 1'b0;
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;

        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

        wr_accept = wr_en && !full;
        rd_accept = rd_en && !empty;

        if (wr_accept) begin
            wr_ptr_next = wr_ptr + PTR_ONE;
        end
        if (rd_accept) begin
            rd_ptr_next = rd_ptr + PTR_ONE;
        end
    end

    // Pointer registers. They wrap naturally modulo 2**(ADDR_WIDTH+1).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr_next;
            rd_ptr <= rd_ptr_next;
        end
    end

    // Storage array written on accepted writes.
    // NOTE: the array has no reset; its contents are don't-care until written, which keeps it RAM-inferable.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    // Registered read data, updated only on an accepted read and held otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else if (rd_accept) begin
            rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        end
    end

`ifdef FIFO_STATUS_EN
    // Occupancy is the pointer difference, so it reads 0 straight out of reset.
    always_comb begin
        level = wr_ptr - rd_ptr;
    end

    // Sticky error flags, set by a rejected request and cleared only by reset_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_async_fifo.sv
// tb_async_fifo: directed bench for async_fifo.
// A vector table covers the ordered write / idle / read pass.
// Hand-written sequences cover reset, the full and empty boundaries,
// simultaneous access, pointer wrap and a mid-traffic reset.
// Build with FIFO_STATUS_EN defined to also check the status outputs.
module tb_async_fifo;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk;
    logic          reset_n;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          empty;
`ifdef FIFO_STATUS_EN
    logic [AW:0]   level;
    logic          overflow;
    logic          underflow;
`endif

    int errors = 0;
    int checks = 0;

    async_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty)
`ifdef FIFO_STATUS_EN
        ,
        .level     (level),
        .overflow  (overflow),
        .underflow (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          wr_en;
        logic          rd_en;
        logic [DW-1:0] wr_data;
        logic          exp_empty;
        logic          exp_full;
        logic [DW-1:0] exp_rd_data;
    } vec_t;

    vec_t vecs[25];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Outputs are sampled 1 ns after the rising edge, well away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle with the given request pattern, then back to idle.
    task automatic cycle(input logic we, input logic re, input logic [DW-1:0] d);
        wr_en   = we;
        rd_en   = re;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
    endtask

    function automatic vec_t mk_vec(input logic we, input logic re, input logic [DW-1:0] d,
                                    input logic e, input logic f, input logic [DW-1:0] q);
        vec_t v;
        v.wr_en       = we;
        v.rd_en       = re;
        v.wr_data     = d;
        v.exp_empty   = e;
        v.exp_full    = f;
        v.exp_rd_data = q;
        return v;
    endfunction

    initial begin
        // Ordered pass: 10 writes of 0x01..0x0A, 5 idle cycles (50 ns), 10 reads.
        for (int i = 0; i < 10; i++) begin
            vecs[i] = mk_vec(1'b1, 1'b0, DW'(i + 1), 1'b0, 1'b0, 8'h00);
        end
        for (int i = 10; i < 15; i++) begin
            vecs[i] = mk_vec(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        end
        for (int i = 15; i < 25; i++) begin
            vecs[i] = mk_vec(1'b0, 1'b1, 8'h00, (i == 24), 1'b0, DW'(i - 14));
        end

        // Reset held low for 20 ns.
        reset_n = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        #20;
        reset_n = 1'b1;
        tick();
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_full", 32'(full), 32'd0);
        check("reset_rd_data", 32'(rd_data), 32'h00);
`ifdef FIFO_STATUS_EN
        check("reset_level", 32'(level), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_underflow", 32'(underflow), 32'd0);
`endif

        // Table-driven ordered write / idle / read.
        for (int i = 0; i < 25; i++) begin
            cycle(vecs[i].wr_en, vecs[i].rd_en, vecs[i].wr_data);
            check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
            check($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].exp_full));
            check($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].exp_rd_data));
        end

        // Full boundary: 16 writes, then a dropped 17th.
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, DW'(8'h10 + i));
            check($sformatf("fill%0d_full", i), 32'(full), 32'(i == 15));
        end
`ifdef FIFO_STATUS_EN
        check("fill_level16", 32'(level), 32'd16);
`endif
        cycle(1'b1, 1'b0, 8'hFF);
        check("write_when_full_full", 32'(full), 32'd1);
`ifdef FIFO_STATUS_EN
        check("overflow_set", 32'(overflow), 32'd1);
        check("overflow_level", 32'(level), 32'd16);
`endif
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            check($sformatf("drain%0d_data", i), 32'(rd_data), 32'(8'h10 + i));
            check($sformatf("drain%0d_empty", i), 32'(empty), 32'(i == 15));
        end

        // Empty boundary: reads on an empty FIFO are ignored.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            check($sformatf("rd_empty%0d_data", i), 32'(rd_data), 32'h1F);
            check($sformatf("rd_empty%0d_empty", i), 32'(empty), 32'd1);
        end
`ifdef FIFO_STATUS_EN
        check("underflow_set", 32'(underflow), 32'd1);
        check("underflow_level", 32'(level), 32'd0);
`endif
        // A write and a read afterwards show the pointers did not move.
        cycle(1'b1, 1'b0, 8'h55);
        check("after_empty_wr_empty", 32'(empty), 32'd0);
        cycle(1'b0, 1'b1, 8'h00);
        check("after_empty_rd_data", 32'(rd_data), 32'h55);
        check("after_empty_rd_empty", 32'(empty), 32'd1);

        // Simultaneous access on an empty FIFO: only the write is taken.
        cycle(1'b1, 1'b1, 8'h66);
        check("simul_empty_empty", 32'(empty), 32'd0);
        check("simul_empty_rd_data", 32'(rd_data), 32'h55);
        cycle(1'b0, 1'b1, 8'h00);
        check("simul_empty_readback", 32'(rd_data), 32'h66);
        check("simul_empty_drained", 32'(empty), 32'd1);

        // Simultaneous access with 5 entries present, across the pointer wrap.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, DW'(8'h20 + i));
        end
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b1, DW'(8'h25 + i));
            check($sformatf("simul%0d_data", i), 32'(rd_data), 32'(8'h20 + i));
            check($sformatf("simul%0d_empty", i), 32'(empty), 32'd0);
`ifdef FIFO_STATUS_EN
            check($sformatf("simul%0d_level", i), 32'(level), 32'd5);
`endif
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            check($sformatf("simul_drain%0d_data", i), 32'(rd_data), 32'(8'h34 + i));
        end
        check("simul_drain_empty", 32'(empty), 32'd1);

        // Full plus simultaneous access: the read is taken and the write is dropped.
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, DW'(8'h40 + i));
        end
        check("full2_full", 32'(full), 32'd1);
        cycle(1'b1, 1'b1, 8'hEE);
        check("full_simul_data", 32'(rd_data), 32'h40);
        check("full_simul_full", 32'(full), 32'd0);
        for (int i = 0; i < 15; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            check($sformatf("full_simul_drain%0d", i), 32'(rd_data), 32'(8'h41 + i));
        end
        check("full_simul_empty", 32'(empty), 32'd1);

        // Reset asserted mid-traffic, between clock edges, takes effect at once.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, DW'(8'h70 + i));
        end
        cycle(1'b0, 1'b1, 8'h00);
        check("pre_reset_data", 32'(rd_data), 32'h70);
        wr_en   = 1'b1;
        wr_data = 8'h99;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_empty", 32'(empty), 32'd1);
        check("async_reset_full", 32'(full), 32'd0);
        check("async_reset_rd_data", 32'(rd_data), 32'h00);
`ifdef FIFO_STATUS_EN
        check("async_reset_overflow", 32'(overflow), 32'd0);
        check("async_reset_underflow", 32'(underflow), 32'd0);
        check("async_reset_level", 32'(level), 32'd0);
`endif
        wr_en = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        check("post_reset_empty", 32'(empty), 32'd1);
        cycle(1'b1, 1'b0, 8'h80);
        cycle(1'b0, 1'b1, 8'h00);
        check("post_reset_data", 32'(rd_data), 32'h80);
        check("post_reset_drained", 32'(empty), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
